// File: rtl/fifo_ram_ctrl.sv
// Pointer/flag controller that wraps a dual-port synchronous RAM into a circular FIFO.
// Optional macro FIFO_RAM_CTRL_PROG_THRESH_EN adds run-time almost-flag thresholds loaded during reset.
module fifo_ram_ctrl #(
    parameter int ADDR_BITS = 6,
    parameter int AF_THRESH = 60,
    parameter int AE_THRESH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
`ifdef FIFO_RAM_CTRL_PROG_THRESH_EN
    input  logic [ADDR_BITS:0]   af_thresh_in,
    input  logic [ADDR_BITS:0]   ae_thresh_in,
`endif
    output logic                 ram_write,
    output logic                 ram_read,
    output logic [ADDR_BITS-1:0] ram_addr_write,
    output logic [ADDR_BITS-1:0] ram_addr_read,
    output logic                 data_valid,
    output logic [ADDR_BITS:0]   count,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int CW = ADDR_BITS + 1;
    localparam logic [ADDR_BITS:0] DEPTH_C = CW'(2 ** ADDR_BITS);
    localparam logic [ADDR_BITS:0] AF_C    = CW'(AF_THRESH);
    localparam logic [ADDR_BITS:0] AE_C    = CW'(AE_THRESH);

    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0]   count_q, count_d;
    logic [ADDR_BITS:0]   af_thr, ae_thr;
    logic                 full_q, empty_q, af_q, ae_q;
    logic                 dv_q, ovf_q, udf_q;
    logic                 push_ok, pop_ok;

    // A push into a full FIFO is safe when a pop is accepted alongside it:
    // the RAM read port returns the old word on a same-address collision.
    always_comb begin
        pop_ok   = pop & ~empty_q;
        push_ok  = push & (~full_q | pop_ok);
        wr_ptr_d = wr_ptr_q + ADDR_BITS'(push_ok);
        rd_ptr_d = rd_ptr_q + ADDR_BITS'(pop_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    end

`ifdef FIFO_RAM_CTRL_PROG_THRESH_EN
    logic [ADDR_BITS:0] af_thr_q, ae_thr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            af_thr_q <= (af_thresh_in != '0 && af_thresh_in <= DEPTH_C) ? af_thresh_in : AF_C;
            ae_thr_q <= (ae_thresh_in < DEPTH_C) ? ae_thresh_in : AE_C;
        end
    end

    assign af_thr = af_thr_q;
    assign ae_thr = ae_thr_q;
`else
    assign af_thr = AF_C;
    assign ae_thr = AE_C;
`endif

    // Flags derive from count_d so they always agree with the registered count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            dv_q     <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == DEPTH_C);
            empty_q  <= (count_d == '0);
            af_q     <= (count_d >= af_thr);
            ae_q     <= (count_d <= ae_thr);
            dv_q     <= pop_ok;
            ovf_q    <= ovf_q | (push & ~push_ok);
            udf_q    <= udf_q | (pop & ~pop_ok);
        end
    end

    assign ram_write      = push_ok & ~reset;
    assign ram_read       = pop_ok & ~reset;
    assign ram_addr_write = wr_ptr_q;
    assign ram_addr_read  = rd_ptr_q;
    assign data_valid     = dv_q;
    assign count          = count_q;
    assign full           = full_q;
    assign empty          = empty_q;
    assign almost_full    = af_q;
    assign almost_empty   = ae_q;
    assign overflow       = ovf_q;
    assign underflow      = udf_q;

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Self-checking bench for fifo_ram_ctrl with a behavioural RAM and a data scoreboard.
module tb_fifo_ram_ctrl;

    localparam int AB    = 6;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [AB:0]   af_thresh_in = '0;
    logic [AB:0]   ae_thresh_in = '0;
    logic          ram_write, ram_read, data_valid;
    logic [AB-1:0] ram_addr_write, ram_addr_read;
    logic [AB:0]   count;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;

    logic [15:0]   wdata = '0;
    logic [15:0]   rdata;
    logic [15:0]   mem [0:DEPTH-1];
    logic [15:0]   sb [$];

    int checks = 0;
    int errors = 0;
    int mcount, mwr, mrd, maf, mae;
    logic movf, mudf, exp_dv, exp_push_ok, exp_pop_ok;

    fifo_ram_ctrl #(.ADDR_BITS(AB), .AF_THRESH(60), .AE_THRESH(4)) dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop),
`ifdef FIFO_RAM_CTRL_PROG_THRESH_EN
        .af_thresh_in(af_thresh_in), .ae_thresh_in(ae_thresh_in),
`endif
        .ram_write(ram_write), .ram_read(ram_read),
        .ram_addr_write(ram_addr_write), .ram_addr_read(ram_addr_read),
        .data_valid(data_valid), .count(count), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_write) mem[ram_addr_write] <= wdata;
        if (ram_read)  rdata <= mem[ram_addr_read];
    end

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs();
        chk(32'(count), 32'(mcount), "count");
        chk(32'(full), 32'(mcount == DEPTH), "full");
        chk(32'(empty), 32'(mcount == 0), "empty");
        chk(32'(almost_full), 32'(mcount >= maf), "almost_full");
        chk(32'(almost_empty), 32'(mcount <= mae), "almost_empty");
        chk(32'(overflow), 32'(movf), "overflow");
        chk(32'(underflow), 32'(mudf), "underflow");
        chk(32'(data_valid), 32'(exp_dv), "data_valid");
        if (exp_dv) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL scoreboard_empty observed=%0h expected=none", rdata);
            end else begin
                chk(32'(rdata), 32'(sb.pop_front()), "rdata");
            end
        end
    endtask

    // Called just after a negedge: drive, check strobes, advance model, check registers.
    task automatic cycle(input logic p, input logic q);
        push  = p;
        pop   = q;
        wdata = 16'($urandom);
        #1;
        exp_pop_ok  = q && (mcount != 0);
        exp_push_ok = p && ((mcount != DEPTH) || exp_pop_ok);
        chk(32'(ram_write), 32'(exp_push_ok), "ram_write");
        chk(32'(ram_read), 32'(exp_pop_ok), "ram_read");
        chk(32'(ram_addr_write), 32'(mwr), "ram_addr_write");
        chk(32'(ram_addr_read), 32'(mrd), "ram_addr_read");
        if (exp_push_ok) sb.push_back(wdata);
        if (p && !exp_push_ok) movf = 1'b1;
        if (q && !exp_pop_ok)  mudf = 1'b1;
        mcount = mcount + int'(exp_push_ok) - int'(exp_pop_ok);
        mwr    = (mwr + int'(exp_push_ok)) % DEPTH;
        mrd    = (mrd + int'(exp_pop_ok)) % DEPTH;
        exp_dv = exp_pop_ok;
        @(posedge clk);
        @(negedge clk);
        check_regs();
    endtask

    task automatic do_reset(input logic p, input logic q, input int af_in, input int ae_in,
                            input int af_exp, input int ae_exp);
        reset = 1'b1;
        push  = p;
        pop   = q;
        af_thresh_in = 7'(af_in);
        ae_thresh_in = 7'(ae_in);
        #1;
        chk(32'(ram_write), 32'd0, "ram_write_in_reset");
        chk(32'(ram_read), 32'd0, "ram_read_in_reset");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        mcount = 0; mwr = 0; mrd = 0;
        movf = 1'b0; mudf = 1'b0; exp_dv = 1'b0;
`ifdef FIFO_RAM_CTRL_PROG_THRESH_EN
        maf = af_exp;
        mae = ae_exp;
`else
        maf = 60;
        mae = 4;
        if (af_exp < 0 || ae_exp < 0) maf = 60;
`endif
        sb.delete();
        chk(32'(ram_addr_write), 32'd0, "wr_ptr_after_reset");
        chk(32'(ram_addr_read), 32'd0, "rd_ptr_after_reset");
        check_regs();
    endtask

    initial begin
        mcount = 0; mwr = 0; mrd = 0; maf = 60; mae = 4;
        movf = 1'b0; mudf = 1'b0; exp_dv = 1'b0;
        @(negedge clk);
        // Out-of-range threshold inputs fall back to the parameters.
        do_reset(1'b0, 1'b0, 0, 64, 60, 4);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);

        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        chk(32'(overflow), 32'd1, "overflow_after_65th_push");

        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        chk(32'(underflow), 32'd1, "underflow_after_extra_pop");

        // Empty + push + pop: only the push lands.
        cycle(1'b1, 1'b1);
        chk(32'(count), 32'd1, "count_empty_push_pop");
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 70; i++) begin
            if (i % 3 == 0) begin
                cycle(1'b1, 1'b0);
                cycle(1'b0, 1'b1);
            end else begin
                cycle(1'b1, 1'b1);
            end
            chk(32'(count <= 7'd3), 32'd1, "count_bounded_wrap");
        end
        while (mcount > 0) cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);

        while (mcount < DEPTH) cycle(1'b1, 1'b0);
        push = 1'b1; pop = 1'b1;
        #1;
        chk(32'(ram_addr_write == ram_addr_read), 32'd1, "full_collision_addr_equal");
        cycle(1'b1, 1'b1);
        chk(32'(full), 32'd1, "full_after_push_pop");
        while (mcount > 0) cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);

        for (int i = 0; i < 37; i++) cycle(1'b1, 1'b0);
        do_reset(1'b1, 1'b1, 10, 4, 10, 4);
        chk(32'(underflow | overflow), 32'd0, "sticky_cleared");
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_ram_ctrl.md
Name: fifo_ram_ctrl

Overview:
- Pointer/flag controller that turns the team's dual-port synchronous RAM (separate write and read addresses, 1-cycle registered read) into a circular FIFO.
- Accepts push/pop requests, drives the RAM write/read strobes and addresses, and tracks occupancy.
- Reports full/empty/almost flags and sticky overflow/underflow errors.
- Emits a data_valid strobe aligned with the RAM's registered data_out.

Parameters:
- ADDR_BITS, 6, RAM address width; FIFO depth DEPTH = 2**ADDR_BITS.
- AF_THRESH, 60, almost_full asserted when count >= AF_THRESH (legal range 1..DEPTH).
- AE_THRESH, 4, almost_empty asserted when count <= AE_THRESH (legal range 0..DEPTH-1).

Ports:
- clk  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high reset
- push  in  1  write request, data presented to RAM data_in externally in the same cycle
- pop  in  1  read request
- ram_write  out  1  RAM write strobe
- ram_read  out  1  RAM read strobe
- ram_addr_write  out  ADDR_BITS  RAM write address
- ram_addr_read  out  ADDR_BITS  RAM read address
- data_valid  out  1  RAM data_out holds popped word this cycle
- count  out  ADDR_BITS+1  occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_THRESH
- almost_empty  out  1  count <= AE_THRESH
- overflow  out  1  sticky: push attempted while full and not accepted
- underflow  out  1  sticky: pop attempted while empty

Behaviour:
- Reset (reset=1 at posedge): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_empty=1 (AE_THRESH>=0), almost_full=0, data_valid=0, overflow=0, underflow=0. While reset=1, ram_write=ram_read=0 combinationally. Reset mid-operation discards contents; no RAM clearing.
- Acceptance (combinational):
  - pop_ok = pop & ~empty
  - push_ok = push & (~full | pop_ok)
- Push while full is accepted only when a pop is accepted in the same cycle. This is legal because the RAM read returns old contents when both ports hit one address.
- ram_write = push_ok; ram_read = pop_ok (both gated by ~reset).
- ram_addr_write = wr_ptr; ram_addr_read = rd_ptr (registered pointers, driven directly).
- Pointers: wr_ptr += push_ok, rd_ptr += pop_ok, modulo DEPTH; natural wrap from DEPTH-1 to 0.
- count_next = count + push_ok - pop_ok; evaluated at ADDR_BITS+1 width, never wraps.
- Flags are registered and computed from count_next, so they are always consistent with count in the same cycle:
  - full = (count_next == DEPTH)
  - empty = (count_next == 0)
  - almost_full = (count_next >= AF_THRESH)
  - almost_empty = (count_next <= AE_THRESH)
- Read latency: data_valid <= pop_ok. It is high exactly one cycle after an accepted pop, coincident with RAM data_out. Back-to-back pops give back-to-back data_valid.
- Simultaneous events:
  - Empty + push + pop: push accepted, pop rejected, underflow set, count -> 1.
  - Full + push + pop: both accepted, count stays DEPTH, full stays 1, no overflow.
  - Mid-range push + pop: count unchanged, both pointers advance.
- Errors: overflow <= overflow | (push & ~push_ok); underflow <= underflow | (pop & ~pop_ok). Both clear only on reset.

Optional Feature:
- Macro FIFO_RAM_CTRL_PROG_THRESH_EN.
- Defined: adds two inputs, af_thresh_in (ADDR_BITS+1 bits) and ae_thresh_in (ADDR_BITS+1 bits).
  - Both are sampled into internal threshold registers on the posedge where reset=1; they load the AF_THRESH/AE_THRESH parameters if the inputs are out of range.
  - The registers replace the parameters in the almost-flag comparisons.
- Undefined: ports absent; thresholds are the constant parameters.

Test Plan:
- Reset then idle 3 cycles -> count=0, empty=1, almost_empty=1, full=0, almost_full=0, data_valid=0, overflow=underflow=0, ram_write=ram_read=0.
- 64 consecutive pushes (ADDR_BITS=6) -> ram_addr_write 0..63. almost_full rises on the edge after the 60th push, full after the 64th. A 65th push gives ram_write=0, overflow=1, count=64.
- From full, 64 consecutive pops -> ram_addr_read 0..63, data_valid high cycles 1..64 after the first pop, matching written data. almost_empty rises when count=4, empty=1 at the end. An extra pop gives ram_read=0, underflow=1.
- Pointer wrap: push 70 / pop 70 interleaved at count≈2 -> addresses wrap 63->0, data order preserved, count never exceeds 3.
- Full + push + pop same cycle -> ram_write=ram_read=1 with both addresses equal, count stays 64, full=1. The popped data is the old word, and the next pop returns the new one only after wrap.
- Reset asserted at count=37 -> next cycle count=0, empty=1, pointers 0, sticky errors cleared. With FIFO_RAM_CTRL_PROG_THRESH_EN and af_thresh_in=10 during reset, almost_full asserts after the 10th push.
